// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
//
// Single-paddle position controller for the pong datapath. One instance drives
// one side of the playfield. It works either from push buttons (with
// acceleration) or by tracking the ball (with a dead-zone and a speed cap). The
// run-time mode input picks between the two.
//
// All movement happens on a slow "tick" derived from clk. The paddle position
// and the status flags are registered and change in the cycle after the tick.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   mode         0 = player (buttons), 1 = AI (ball tracking)
//   enable       1 = movement allowed, 0 = freeze position
//   button_up    raw asynchronous button, synchronised internally
//   button_down  raw asynchronous button, synchronised internally
//   ball_y       ball centre Y
//   ball_valid   ball_y is meaningful
//   paddle_y     paddle top edge, 0..SCREEN_H-PADDLE_H
//   moving_up    paddle_y decreased on the last tick
//   moving_down  paddle_y increased on the last tick
//   at_top       paddle_y == 0
//   at_bottom    paddle_y == SCREEN_H-PADDLE_H
// -----------------------------------------------------------------------------
module paddle_ctrl #(
  parameter int Y_W         = 10,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 64,
  parameter int TICK_DIV    = 416667,
  parameter int MAX_SPEED   = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int AI_SPEED    = 3,
  parameter int AI_DEADZONE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode,
  input  logic           enable,
  input  logic           button_up,
  input  logic           button_down,
  input  logic [Y_W-1:0] ball_y,
  input  logic           ball_valid,
  output logic [Y_W-1:0] paddle_y,
  output logic           moving_up,
  output logic           moving_down,
  output logic           at_top,
  output logic           at_bottom
);

  // Position arithmetic runs two bits wider and signed, so that moving past
  // either edge, or subtracting half a paddle from a small ball_y, goes
  // negative or overshoots instead of wrapping.
  localparam int S_W   = Y_W + 2;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  localparam int HLD_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [Y_W-1:0]          Y_MAX    = Y_W'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0]          Y_RST    = Y_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic signed [S_W-1:0]   Y_MAX_S  = S_W'(SCREEN_H - PADDLE_H);
  localparam logic signed [S_W-1:0]   HALF_H_S = S_W'(PADDLE_H / 2);
  localparam logic signed [S_W-1:0]   AI_SPD_S = S_W'(AI_SPEED);
  localparam logic signed [S_W-1:0]   DZ_S     = S_W'(AI_DEADZONE);
  localparam logic signed [S_W-1:0]   ONE_S    = S_W'(1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SPD_W-1:0]        SPD_ONE  = SPD_W'(1);
  localparam logic [SPD_W-1:0]        SPD_MAX  = SPD_W'(MAX_SPEED);
  localparam logic [HLD_W-1:0]        HLD_LAST = HLD_W'(ACCEL_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Saturate a wide signed position into the legal paddle range.
  function automatic logic [Y_W-1:0] sat_y(input logic signed [S_W-1:0] v);
    if (v < 0) begin
      sat_y = '0;
    end else if (v > Y_MAX_S) begin
      sat_y = Y_MAX;
    end else begin
      sat_y = v[Y_W-1:0];
    end
  endfunction

  function automatic logic signed [S_W-1:0] abs_s(input logic signed [S_W-1:0] v);
    abs_s = (v < 0) ? -v : v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             up_meta_q,   up_meta_d;
  logic             up_sync_q,   up_sync_d;
  logic             dn_meta_q,   dn_meta_d;
  logic             dn_sync_q,   dn_sync_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [SPD_W-1:0] speed_q,     speed_d;
  logic [HLD_W-1:0] hold_q,      hold_d;
  state_t           state_q,     state_d;
  logic [Y_W-1:0]   paddle_y_q,  paddle_y_d;
  logic             mv_up_q,     mv_up_d;
  logic             mv_dn_q,     mv_dn_d;
  logic             at_top_q,    at_top_d;
  logic             at_bot_q,    at_bot_d;

  // Combinational intermediates
  logic                  tick;
  state_t                req;
  logic [HLD_W-1:0]      hold_inc;
  logic signed [S_W-1:0] y_s;
  logic signed [S_W-1:0] spd_s;
  logic signed [S_W-1:0] ball_s;
  logic signed [S_W-1:0] tgt_s;
  logic signed [S_W-1:0] err_s;
  logic signed [S_W-1:0] err_abs;
  logic signed [S_W-1:0] step_s;
  logic signed [S_W-1:0] delta_s;
  logic [Y_W-1:0]        y_new;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    up_meta_d  = button_up;
    up_sync_d  = up_meta_q;
    dn_meta_d  = button_down;
    dn_sync_d  = dn_meta_q;
    speed_d    = speed_q;
    hold_d     = hold_q;
    state_d    = state_q;
    paddle_y_d = paddle_y_q;
    mv_up_d    = mv_up_q;
    mv_dn_d    = mv_dn_q;
    at_top_d   = at_top_q;
    at_bot_d   = at_bot_q;

    tick     = (cnt_q == CNT_LAST);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    req      = IDLE;
    hold_inc = hold_q + 1'b1;
    y_s      = $signed({2'b00, paddle_y_q});
    spd_s    = $signed({{(S_W - SPD_W){1'b0}}, speed_q});
    ball_s   = $signed({2'b00, ball_y});
    tgt_s    = $signed({2'b00, sat_y(ball_s - HALF_H_S)});
    err_s    = tgt_s - y_s;
    err_abs  = abs_s(err_s);
    step_s   = (err_abs < AI_SPD_S) ? err_abs : AI_SPD_S;
    delta_s  = '0;
    y_new    = paddle_y_q;

    if (up_sync_q && !dn_sync_q) begin
      req = UP;
    end else if (dn_sync_q && !up_sync_q) begin
      req = DOWN;
    end

    if (tick) begin
      if (!enable || mode) begin
        // Frozen or AI-driven: the button FSM is parked so that a later
        // switch into player mode always starts from rest at speed 1.
        state_d = IDLE;
        speed_d = SPD_ONE;
        hold_d  = '0;
        if (enable && ball_valid && (err_abs > DZ_S)) begin
          delta_s = (err_s < 0) ? -step_s : step_s;
        end
      end else if (req != state_q) begin
        // A new (or released) request restarts the acceleration ramp.
        state_d = req;
        speed_d = SPD_ONE;
        hold_d  = '0;
        if (req == UP) begin
          delta_s = -ONE_S;
        end else if (req == DOWN) begin
          delta_s = ONE_S;
        end
      end else if (req != IDLE) begin
        delta_s = (req == UP) ? -spd_s : spd_s;
        if (hold_inc >= HLD_LAST) begin
          if (speed_q < SPD_MAX) begin
            speed_d = speed_q + 1'b1;
            hold_d  = '0;
          end else begin
            // Top speed reached: park the hold counter so it cannot wrap.
            hold_d = HLD_LAST;
          end
        end else begin
          hold_d = hold_inc;
        end
      end

      y_new      = sat_y(y_s + delta_s);
      paddle_y_d = y_new;
      mv_up_d    = (y_new < paddle_y_q);
      mv_dn_d    = (y_new > paddle_y_q);
      at_top_d   = (y_new == '0);
      at_bot_d   = (y_new == Y_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      up_meta_q  <= 1'b0;
      up_sync_q  <= 1'b0;
      dn_meta_q  <= 1'b0;
      dn_sync_q  <= 1'b0;
      cnt_q      <= '0;
      speed_q    <= SPD_ONE;
      hold_q     <= '0;
      state_q    <= IDLE;
      paddle_y_q <= Y_RST;
      mv_up_q    <= 1'b0;
      mv_dn_q    <= 1'b0;
      at_top_q   <= 1'b0;
      at_bot_q   <= 1'b0;
    end else begin
      up_meta_q  <= up_meta_d;
      up_sync_q  <= up_sync_d;
      dn_meta_q  <= dn_meta_d;
      dn_sync_q  <= dn_sync_d;
      cnt_q      <= cnt_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      paddle_y_q <= paddle_y_d;
      mv_up_q    <= mv_up_d;
      mv_dn_q    <= mv_dn_d;
      at_top_q   <= at_top_d;
      at_bot_q   <= at_bot_d;
    end
  end

  assign paddle_y    = paddle_y_q;
  assign moving_up   = mv_up_q;
  assign moving_down = mv_dn_q;
  assign at_top      = at_top_q;
  assign at_bottom   = at_bot_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_ctrl
//
// Bench for paddle_ctrl with a short tick period. A table of directed steps
// (inputs held for N ticks, then expected position and flags) walks through
// the acceleration ramp, edge clamping, direction reversal, both-buttons, AI
// tracking, dead-zone, ball_valid and enable gating. A hand-written sequence
// covers a mid-tick reset. A behavioural model (plain integer arithmetic on
// position, speed and a held-tick count) is stepped on every clock edge and
// compared every cycle, including a randomized phase at the end.
// -----------------------------------------------------------------------------
module tb_paddle_ctrl;

  localparam int Y_W  = 10;
  localparam int SH   = 480;
  localparam int PH   = 64;
  localparam int TD   = 4;
  localparam int MS   = 4;
  localparam int AT   = 8;
  localparam int AIS  = 3;
  localparam int DZ   = 4;
  localparam int YMAX = SH - PH;
  localparam int YRST = (SH - PH) / 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic           enable;
  logic           button_up;
  logic           button_down;
  logic [Y_W-1:0] ball_y;
  logic           ball_valid;
  logic [Y_W-1:0] paddle_y;
  logic           moving_up;
  logic           moving_down;
  logic           at_top;
  logic           at_bottom;

  paddle_ctrl #(
    .Y_W(Y_W), .SCREEN_H(SH), .PADDLE_H(PH), .TICK_DIV(TD),
    .MAX_SPEED(MS), .ACCEL_TICKS(AT), .AI_SPEED(AIS), .AI_DEADZONE(DZ)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .enable(enable),
    .button_up(button_up), .button_down(button_down),
    .ball_y(ball_y), .ball_valid(ball_valid),
    .paddle_y(paddle_y), .moving_up(moving_up), .moving_down(moving_down),
    .at_top(at_top), .at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_cnt, m_y, m_spd, m_held, m_dir;
  bit m_mu, m_md, m_top, m_bot;
  bit m_u1, m_u2, m_d1, m_d2;

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > YMAX) return YMAX;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_edge();
    int new_y, tgt, err, req, mag;
    if (!reset) begin
      m_cnt = 0; m_y = YRST; m_spd = 1; m_held = 0; m_dir = 0;
      m_mu = 0; m_md = 0; m_top = 0; m_bot = 0;
      m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0;
      return;
    end
    if (m_cnt == TD - 1) begin
      m_cnt = 0;
      new_y = m_y;
      if (!enable || mode) begin
        m_dir = 0; m_spd = 1; m_held = 0;
        if (enable && ball_valid) begin
          tgt = clampi(int'(ball_y) - PH / 2);
          err = tgt - m_y;
          if (absi(err) > DZ) begin
            mag = (absi(err) < AIS) ? absi(err) : AIS;
            new_y = m_y + ((err < 0) ? -mag : mag);
          end
        end
      end else begin
        // -1 = up, +1 = down, 0 = none; both pressed counts as none.
        req = (m_u2 && !m_d2) ? -1 : ((m_d2 && !m_u2) ? 1 : 0);
        if (req != m_dir) begin
          m_dir = req; m_spd = 1; m_held = 0;
          new_y = m_y + req;
        end else if (req != 0) begin
          new_y = m_y + req * m_spd;
          m_held++;
          if (m_held == AT - 1 && m_spd < MS) begin
            m_spd++;
            m_held = 0;
          end
        end
      end
      new_y = clampi(new_y);
      m_mu  = new_y < m_y;
      m_md  = new_y > m_y;
      m_y   = new_y;
      m_top = (m_y == 0);
      m_bot = (m_y == YMAX);
    end else begin
      m_cnt++;
    end
    m_u2 = m_u1; m_u1 = button_up;
    m_d2 = m_d1; m_d1 = button_down;
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle_model", {paddle_y, moving_up, moving_down, at_top, at_bottom},
          {Y_W'(m_y), m_mu, m_md, m_top, m_bot});
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TD) step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit mode, en, up, dn, bv;
    int by;
    int nticks;
    int y;
    bit mu, md, top, bot;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{0,1,0,0,0,   0, 10, 208, 0,0,0,0}; // idle after reset
    tbl[1]  = '{0,1,1,0,0,   0,  1, 207, 1,0,0,0}; // first press: 1 px
    tbl[2]  = '{0,1,1,0,0,   0,  7, 200, 1,0,0,0}; // rest of speed 1
    tbl[3]  = '{0,1,1,0,0,   0,  7, 186, 1,0,0,0}; // speed 2
    tbl[4]  = '{0,1,1,0,0,   0,  7, 165, 1,0,0,0}; // speed 3
    tbl[5]  = '{0,1,1,0,0,   0,  5, 145, 1,0,0,0}; // speed 4
    tbl[6]  = '{0,1,1,0,0,   0, 40,   0, 0,0,1,0}; // saturates at top
    tbl[7]  = '{0,1,0,1,0,   0,  1,   1, 0,1,0,0}; // reversal: 1 px
    tbl[8]  = '{0,1,0,1,0,   0,  7,   8, 0,1,0,0};
    tbl[9]  = '{0,1,0,1,0,   0,  7,  22, 0,1,0,0};
    tbl[10] = '{0,1,0,1,0,   0,  2,  28, 0,1,0,0}; // at speed 3
    tbl[11] = '{0,1,1,0,0,   0,  1,  27, 1,0,0,0}; // up mid-run: 1 px
    tbl[12] = '{0,1,1,1,0,   0,  3,  27, 0,0,0,0}; // both held: still
    tbl[13] = '{1,1,0,0,1, 400,120, 366, 0,0,0,0}; // AI toward 368
    tbl[14] = '{1,1,0,0,1,  10,130,   3, 0,0,0,0}; // target clamps to 0
    tbl[15] = '{1,1,0,0,0,  50,  5,   3, 0,0,0,0}; // ball invalid
    tbl[16] = '{1,0,0,0,1, 300,  5,   3, 0,0,0,0}; // disabled
    tbl[17] = '{1,1,0,0,1, 300,  1,   6, 0,1,0,0}; // re-enabled: +3
    tbl[18] = '{1,1,0,0,1,1023,200, 414, 0,0,0,0}; // target clamps to 416
    tbl[19] = '{0,1,0,1,0,   0, 60, 416, 0,0,0,1}; // player to bottom
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0; mode = 1'b0; enable = 1'b1;
    button_up = 1'b0; button_down = 1'b0;
    ball_y = '0; ball_valid = 1'b0;

    repeat (3) step();
    check("reset_state", {paddle_y, moving_up, moving_down, at_top, at_bottom},
          {10'd208, 4'b0000});
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      mode = tbl[i].mode; enable = tbl[i].en;
      button_up = tbl[i].up; button_down = tbl[i].dn;
      ball_valid = tbl[i].bv; ball_y = Y_W'(tbl[i].by);
      run_ticks(tbl[i].nticks);
      check($sformatf("vec%0d", i),
            {paddle_y, moving_up, moving_down, at_top, at_bottom},
            {Y_W'(tbl[i].y), tbl[i].mu, tbl[i].md, tbl[i].top, tbl[i].bot});
    end

    // Mid-tick reset while running up at top speed.
    button_up = 1'b1; button_down = 1'b0;
    run_ticks(25);
    check("pre_reset_y", 32'(paddle_y), 32'd361);
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_reset", {paddle_y, moving_up, moving_down, at_top, at_bottom},
          {10'd208, 4'b0000});
    run_ticks(1);
    check("restart_1px", {paddle_y, moving_up}, {10'd207, 1'b1});
    run_ticks(1);
    check("restart_speed1", 32'(paddle_y), 32'd206);

    // Randomized phase, compared against the model every cycle.
    for (int i = 0; i < 2400; i++) begin
      if ($urandom_range(0, 7) == 0)   button_up   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)   button_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) mode        = ~mode;
      if ($urandom_range(0, 59) == 0)  enable      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0)  ball_y      = Y_W'($urandom_range(0, 1023));
      if ($urandom_range(0, 39) == 0)  ball_valid  = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
